mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction-fetch stage and the memory-access stage. Both requesters share one physical memory bus. The arbiter accepts one request at a time and drives it onto the bus. It then waits for the bus response and returns the data to the owning requester. Memory-stage requests have priority, and a starvation counter guarantees that fetch still makes forward progress.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the arbiter, the fetch and memory stages, and the shared bus.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            if_req_valid;
    logic [XLEN-1:0] if_req_addr;
    logic            if_req_ready;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rsp_data;

    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_wen;
    logic [XLEN-1:0] mem_req_wdata;
    logic [7:0]      mem_req_wmask;
    logic            mem_req_ready;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    logic            bus_req_valid;
    logic [XLEN-1:0] bus_req_addr;
    logic            bus_req_wen;
    logic [XLEN-1:0] bus_req_wdata;
    logic [7:0]      bus_req_wmask;
    logic            bus_req_ready;
    logic            bus_rsp_valid;
    logic [XLEN-1:0] bus_rsp_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: memory stage has priority, fetch is forced through after
// STARVE_LIMIT consecutive lost arbitrations. One outstanding bus transaction at a time.
module mem_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave io
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e          state_q, state_d;
    logic [3:0]      starve_cnt_q;
    logic            owner_q;
    logic [XLEN-1:0] req_addr_q, req_wdata_q;
    logic            req_wen_q;
    logic [7:0]      req_wmask_q;
    logic            if_rsp_valid_q, mem_rsp_valid_q;
    logic [XLEN-1:0] if_rsp_data_q, mem_rsp_data_q;
    logic            starved, grant_if, grant_mem;

    assign starved = (starve_cnt_q == StarveMax);

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (starved && io.if_req_valid) begin
                grant_if = 1'b1;
            end else if (io.mem_req_valid) begin
                grant_mem = 1'b1;
            end else if (io.if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_if || grant_mem) state_d = StIssue;
            StIssue: if (io.bus_req_ready) state_d = StWait;
            StWait:  if (io.bus_rsp_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        io.if_req_ready  = grant_if;
        io.mem_req_ready = grant_mem;
        io.bus_req_valid = (state_q == StIssue);
        io.bus_req_addr  = req_addr_q;
        io.bus_req_wen   = req_wen_q;
        io.bus_req_wdata = req_wdata_q;
        io.bus_req_wmask = req_wmask_q & {8{req_wen_q}};
        io.if_rsp_valid  = if_rsp_valid_q;
        io.if_rsp_data   = if_rsp_data_q;
        io.mem_rsp_valid = mem_rsp_valid_q;
        io.mem_rsp_data  = mem_rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q    <= '0;
            owner_q         <= 1'b0;
            req_addr_q      <= '0;
            req_wen_q       <= 1'b0;
            req_wdata_q     <= '0;
            req_wmask_q     <= '0;
            if_rsp_valid_q  <= 1'b0;
            mem_rsp_valid_q <= 1'b0;
            if_rsp_data_q   <= '0;
            mem_rsp_data_q  <= '0;
        end else begin
            if_rsp_valid_q  <= 1'b0;
            mem_rsp_valid_q <= 1'b0;
            if (grant_if) begin
                req_addr_q   <= io.if_req_addr;
                req_wen_q    <= 1'b0;
                req_wdata_q  <= '0;
                req_wmask_q  <= '0;
                owner_q      <= 1'b0;
                starve_cnt_q <= '0;
            end else if (grant_mem) begin
                req_addr_q  <= io.mem_req_addr;
                req_wen_q   <= io.mem_req_wen;
                req_wdata_q <= io.mem_req_wdata;
                req_wmask_q <= io.mem_req_wmask;
                owner_q     <= 1'b1;
                if (io.if_req_valid && !starved) starve_cnt_q <= starve_cnt_q + 4'd1;
            end
            // Responses outside WAIT are protocol violations and are dropped.
            if (state_q == StWait && io.bus_rsp_valid) begin
                if (owner_q) begin
                    mem_rsp_valid_q <= 1'b1;
                    mem_rsp_data_q  <= req_wen_q ? '0 : io.bus_rsp_data;
                end else begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_data_q  <= io.bus_rsp_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random rounds checked
// against a transaction-level model of grant order, bus fields and responses.
module tb_mem_arbiter;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN)) io ();

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side model state
    bit          if_pend, mem_pend, hold_both;
    int          lost;
    logic [63:0] if_addr, m_addr, m_wdata;
    logic        m_wen;
    logic [7:0]  m_wmask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        io.if_req_valid  = if_pend;
        io.if_req_addr   = if_addr;
        io.mem_req_valid = mem_pend;
        io.mem_req_addr  = m_addr;
        io.mem_req_wen   = m_wen;
        io.mem_req_wdata = m_wdata;
        io.mem_req_wmask = m_wmask;
    endtask

    // One full transaction starting in an IDLE cycle; ends in the cycle of the rsp pulse.
    task automatic do_round(input int s1, input int s2, input logic [63:0] rdata);
        bit          win_if;
        logic [63:0] e_addr, e_wdata;
        logic        e_wen;
        logic [7:0]  e_mask;
        win_if = if_pend && (lost == LIMIT || !mem_pend);
        drive_reqs();
        #1;
        chk("if_req_ready", io.if_req_ready, win_if);
        chk("mem_req_ready", io.mem_req_ready, !win_if);
        if (win_if) lost = 0;
        else if (if_pend && lost < LIMIT) lost++;
        e_addr  = win_if ? if_addr : m_addr;
        e_wen   = win_if ? 1'b0 : m_wen;
        e_wdata = win_if ? 64'd0 : m_wdata;
        e_mask  = (win_if || !m_wen) ? 8'h00 : m_wmask;
        io.bus_req_ready = 1'b0;
        tick();
        if (!hold_both) begin
            if (win_if) if_pend = 0;
            else mem_pend = 0;
            drive_reqs();
        end
        for (int k = 0; k <= s1; k++) begin
            #1;
            chk("issue bus_req_valid", io.bus_req_valid, 1'b1);
            chk("issue bus_req_addr", io.bus_req_addr, e_addr);
            chk("issue bus_req_wen", io.bus_req_wen, e_wen);
            chk("issue bus_req_wdata", io.bus_req_wdata, e_wdata);
            chk("issue bus_req_wmask", io.bus_req_wmask, e_mask);
            chk("issue if_req_ready", io.if_req_ready, 1'b0);
            chk("issue mem_req_ready", io.mem_req_ready, 1'b0);
            chk("issue if_rsp_valid", io.if_rsp_valid, 1'b0);
            chk("issue mem_rsp_valid", io.mem_rsp_valid, 1'b0);
            io.bus_req_ready = (k == s1);
            io.bus_rsp_valid = ($urandom_range(0, 3) == 0);
            tick();
        end
        io.bus_req_ready = 1'b0;
        io.bus_rsp_valid = 1'b0;
        for (int k = 0; k < s2; k++) begin
            #1;
            chk("wait bus_req_valid", io.bus_req_valid, 1'b0);
            chk("wait if_req_ready", io.if_req_ready, 1'b0);
            chk("wait mem_req_ready", io.mem_req_ready, 1'b0);
            chk("wait rsp_valid", {io.if_rsp_valid, io.mem_rsp_valid}, 2'b00);
            tick();
        end
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data  = rdata;
        #1;
        chk("wait bus_req_valid", io.bus_req_valid, 1'b0);
        tick();
        io.bus_rsp_valid = 1'b0;
        chk("if_rsp_valid", io.if_rsp_valid, win_if);
        chk("mem_rsp_valid", io.mem_rsp_valid, !win_if);
        if (win_if) chk("if_rsp_data", io.if_rsp_data, rdata);
        else chk("mem_rsp_data", io.mem_rsp_data, e_wen ? 64'd0 : rdata);
    endtask

    initial begin
        if_pend = 0; mem_pend = 0; hold_both = 0; lost = 0;
        if_addr = '0; m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
        io.bus_req_ready = 0; io.bus_rsp_valid = 0; io.bus_rsp_data = '0;
        drive_reqs();

        // Reset with both requesters asserting: nothing may be accepted.
        rst = 1'b1;
        io.if_req_valid  = 1'b1;
        io.mem_req_valid = 1'b1;
        tick();
        tick();
        #1;
        chk("reset if_req_ready", io.if_req_ready, 1'b0);
        chk("reset mem_req_ready", io.mem_req_ready, 1'b0);
        chk("reset bus_req_valid", io.bus_req_valid, 1'b0);
        chk("reset bus_req_addr", io.bus_req_addr, 64'd0);
        chk("reset rsp_valid", {io.if_rsp_valid, io.mem_rsp_valid}, 2'b00);
        chk("reset if_rsp_data", io.if_rsp_data, 64'd0);
        chk("reset mem_rsp_data", io.mem_rsp_data, 64'd0);
        rst = 1'b0;
        drive_reqs();
        tick();

        // Single IF read, best case
        if_pend = 1; if_addr = 64'h0000_0000_8000_0000;
        do_round(0, 0, 64'h1122_3344_5566_7788);

        // Store: rsp data must be 0
        mem_pend = 1; m_addr = 64'h8000_1000; m_wen = 1; m_wdata = 64'hAB; m_wmask = 8'h01;
        do_round(0, 0, 64'hDEAD_BEEF_0000_0001);

        // Load with a full mask: bus mask must be forced to 0
        mem_pend = 1; m_addr = 64'h8000_2008; m_wen = 0; m_wdata = 64'h55; m_wmask = 8'hFF;
        do_round(0, 1, 64'hCAFE_F00D_1234_5678);

        // Backpressure for 5 cycles with IF waiting behind a load
        if_pend = 1; if_addr = 64'h8000_0040;
        mem_pend = 1; m_addr = 64'h8000_3000; m_wen = 0; m_wmask = 8'h0F;
        do_round(5, 0, 64'h0BAD_0BAD_0BAD_0BAD);
        do_round(0, 0, 64'h0102_0304_0506_0708);

        // Contention with both valids held: MEM x4, IF, MEM x4, IF
        hold_both = 1;
        if_pend = 1; if_addr = 64'h8000_0100;
        mem_pend = 1; m_addr = 64'h8000_4000; m_wen = 1; m_wdata = 64'h77; m_wmask = 8'hF0;
        for (int i = 0; i < 10; i++) begin
            drive_reqs();
            #1;
            chk("contention if grant", io.if_req_ready, (i == 4 || i == 9));
            do_round(0, 0, {$urandom, $urandom});
        end
        hold_both = 0;
        do_round(0, 0, {$urandom, $urandom});
        do_round(0, 0, {$urandom, $urandom});

        // Reset while in WAIT, then a late response that must be ignored
        if_pend = 1; if_addr = 64'h8000_0200;
        drive_reqs();
        #1;
        chk("rstwait accept", io.if_req_ready, 1'b1);
        tick();
        if_pend = 0;
        drive_reqs();
        io.bus_req_ready = 1'b1;
        tick();
        io.bus_req_ready = 1'b0;
        #1;
        chk("rstwait in wait", io.bus_req_valid, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstwait bus_req_valid", io.bus_req_valid, 1'b0);
        io.bus_rsp_valid = 1'b1;
        io.bus_rsp_data  = 64'hFFFF_0000_FFFF_0000;
        tick();
        io.bus_rsp_valid = 1'b0;
        chk("rstwait no pulse", {io.if_rsp_valid, io.mem_rsp_valid}, 2'b00);
        tick();
        chk("rstwait no pulse later", {io.if_rsp_valid, io.mem_rsp_valid}, 2'b00);
        lost = 0;
        if_pend = 1; if_addr = 64'h8000_0204;
        do_round(0, 0, 64'h4242_4242_4242_4242);

        // Random rounds
        for (int r = 0; r < 60; r++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1; if_addr = {$urandom, $urandom};
            end
            if (!mem_pend && $urandom_range(0, 1) == 1) begin
                mem_pend = 1; m_addr = {$urandom, $urandom}; m_wen = 1'($urandom_range(0, 1));
                m_wdata = {$urandom, $urandom}; m_wmask = 8'($urandom);
            end
            if (!if_pend && !mem_pend) begin
                drive_reqs();
                io.bus_rsp_valid = 1'b1;
                #1;
                chk("idle readies", {io.if_req_ready, io.mem_req_ready}, 2'b00);
                tick();
                io.bus_rsp_valid = 1'b0;
                chk("idle stray rsp", {io.if_rsp_valid, io.mem_rsp_valid}, 2'b00);
            end else begin
                do_round($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
